// File: rtl/pwl_act_pipe.sv
// Runtime-programmable piecewise-linear activation, 3-stage valid/ready pipeline.
// Double-buffered segment table; commits swap only once the pipeline has drained.
module pwl_act_pipe #(
    parameter  int DATA_W  = 16,
    parameter  int FRAC_W  = 9,
    parameter  int SEG_N   = 16,
    parameter  int SHIFT_W = 4,
    localparam int SEG_W   = $clog2(SEG_N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_x,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_y,
    input  logic               cfg_we,
    input  logic [SEG_W-1:0]   cfg_addr,
    input  logic [DATA_W-1:0]  cfg_bp,
    input  logic [DATA_W-1:0]  cfg_xoff,
    input  logic [SHIFT_W-1:0] cfg_shift,
    input  logic               cfg_neg,
    input  logic               cfg_zero,
    input  logic [DATA_W-1:0]  cfg_bias,
    input  logic               cfg_commit,
    output logic               cfg_busy
);

    if (FRAC_W < 0 || FRAC_W >= DATA_W) begin : g_frac_w_invalid
        $error("FRAC_W must lie in [0, DATA_W)");
    end

    localparam logic [DATA_W-1:0] BP_MAX = {1'b0, {(DATA_W-1){1'b1}}};

    typedef enum logic [1:0] {RUN, DRAIN, SWAP} state_t;

    state_t state_q;
    logic   busy_q;

    logic [DATA_W-1:0]  sh_bp_q   [SEG_N];
    logic [DATA_W-1:0]  sh_xoff_q [SEG_N];
    logic [SHIFT_W-1:0] sh_shift_q[SEG_N];
    logic               sh_neg_q  [SEG_N];
    logic               sh_zero_q [SEG_N];
    logic [DATA_W-1:0]  sh_bias_q [SEG_N];

    logic [DATA_W-1:0]  act_bp_q   [SEG_N];
    logic [DATA_W-1:0]  act_xoff_q [SEG_N];
    logic [SHIFT_W-1:0] act_shift_q[SEG_N];
    logic               act_neg_q  [SEG_N];
    logic               act_zero_q [SEG_N];
    logic [DATA_W-1:0]  act_bias_q [SEG_N];

    logic               v1_q, v2_q, v3_q;
    logic [DATA_W-1:0]  x1_q;
    logic [SEG_W-1:0]   seg1_q;
    logic [DATA_W:0]    d2_q;
    logic [SHIFT_W-1:0] sh2_q;
    logic               neg2_q, zero2_q;
    logic [DATA_W-1:0]  bias2_q;
    logic [DATA_W-1:0]  y3_q;

    logic stall, en1, en2, en3, accept;

    assign stall    = v3_q && !out_ready;
    assign en3      = !stall;
    assign en2      = !v2_q || en3;
    assign en1      = !v1_q || en2;
    assign in_ready = !stall && (state_q == RUN);
    assign accept   = in_valid && in_ready;

    assign out_valid = v3_q;
    assign out_y     = y3_q;
    assign cfg_busy  = busy_q;

    logic [SEG_W-1:0] seg_d;

    always_comb begin
        seg_d = '0;
        for (int i = 0; i < SEG_N - 1; i++) begin
            if ($signed(in_x) >= $signed(act_bp_q[i])) begin
                seg_d = seg_d + SEG_W'(1);
            end
        end
    end

    logic [DATA_W:0] d2_d;

    assign d2_d = {x1_q[DATA_W-1], x1_q}
                - {act_xoff_q[seg1_q][DATA_W-1], act_xoff_q[seg1_q]};

    logic signed [DATA_W:0]   t_sh, t_sel;
    logic signed [DATA_W+1:0] s_sum;
    logic        [DATA_W-1:0] y_d;

    always_comb begin
        t_sh  = $signed(d2_q) >>> sh2_q;
        t_sel = zero2_q ? '0 : (neg2_q ? -t_sh : t_sh);
        s_sum = {t_sel[DATA_W], t_sel}
              + {{2{bias2_q[DATA_W-1]}}, bias2_q};
        // In range only when the top three bits agree.
        if (&s_sum[DATA_W+1:DATA_W-1] || ~|s_sum[DATA_W+1:DATA_W-1]) begin
            y_d = s_sum[DATA_W-1:0];
        end else if (s_sum[DATA_W+1]) begin
            y_d = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            y_d = BP_MAX;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            x1_q    <= '0;
            seg1_q  <= '0;
            d2_q    <= '0;
            sh2_q   <= '0;
            neg2_q  <= 1'b0;
            zero2_q <= 1'b0;
            bias2_q <= '0;
            y3_q    <= '0;
        end else begin
            if (en1) begin
                v1_q <= accept;
            end
            if (accept) begin
                x1_q   <= in_x;
                seg1_q <= seg_d;
            end
            if (en2) begin
                v2_q <= v1_q;
            end
            if (en2 && v1_q) begin
                d2_q    <= d2_d;
                sh2_q   <= act_shift_q[seg1_q];
                neg2_q  <= act_neg_q[seg1_q];
                zero2_q <= act_zero_q[seg1_q];
                bias2_q <= act_bias_q[seg1_q];
            end
            if (en3) begin
                v3_q <= v2_q;
            end
            if (en3 && v2_q) begin
                y3_q <= y_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (cfg_commit) begin
                        state_q <= DRAIN;
                        busy_q  <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (!v1_q && !v2_q && !v3_q) begin
                        state_q <= SWAP;
                    end
                end
                SWAP: begin
                    state_q <= RUN;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= RUN;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SEG_N; i++) begin
                sh_bp_q[i]     <= BP_MAX;
                sh_xoff_q[i]   <= '0;
                sh_shift_q[i]  <= '0;
                sh_neg_q[i]    <= 1'b0;
                sh_zero_q[i]   <= 1'b0;
                sh_bias_q[i]   <= '0;
                act_bp_q[i]    <= BP_MAX;
                act_xoff_q[i]  <= '0;
                act_shift_q[i] <= '0;
                act_neg_q[i]   <= 1'b0;
                act_zero_q[i]  <= 1'b0;
                act_bias_q[i]  <= '0;
            end
        end else begin
            if (cfg_we) begin
                sh_bp_q[cfg_addr]    <= cfg_bp;
                sh_xoff_q[cfg_addr]  <= cfg_xoff;
                sh_shift_q[cfg_addr] <= cfg_shift;
                sh_neg_q[cfg_addr]   <= cfg_neg;
                sh_zero_q[cfg_addr]  <= cfg_zero;
                sh_bias_q[cfg_addr]  <= cfg_bias;
            end
            if (state_q == SWAP) begin
                for (int i = 0; i < SEG_N; i++) begin
                    act_bp_q[i]    <= sh_bp_q[i];
                    act_xoff_q[i]  <= sh_xoff_q[i];
                    act_shift_q[i] <= sh_shift_q[i];
                    act_neg_q[i]   <= sh_neg_q[i];
                    act_zero_q[i]  <= sh_zero_q[i];
                    act_bias_q[i]  <= sh_bias_q[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_pwl_act_pipe.sv
// Directed bench for pwl_act_pipe: identity, ReLU, SiLU segment, saturation,
// backpressure, commit with data in flight, asynchronous reset mid-stream.
module tb_pwl_act_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_x = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_y;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_addr = '0;
    logic [15:0] cfg_bp = '0;
    logic [15:0] cfg_xoff = '0;
    logic [3:0]  cfg_shift = '0;
    logic        cfg_neg = 1'b0;
    logic        cfg_zero = 1'b0;
    logic [15:0] cfg_bias = '0;
    logic        cfg_commit = 1'b0;
    logic        cfg_busy;

    pwl_act_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_bp(cfg_bp),
        .cfg_xoff(cfg_xoff), .cfg_shift(cfg_shift), .cfg_neg(cfg_neg),
        .cfg_zero(cfg_zero), .cfg_bias(cfg_bias),
        .cfg_commit(cfg_commit), .cfg_busy(cfg_busy)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] rcv[$];
    logic [15:0] stim[16];
    logic [15:0] expv[16];
    int          nstim;

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) rcv.push_back(out_y);
    end

    task automatic push_all(output int accepted, output int cycles);
        logic ok;
        int   g;
        accepted = 0;
        cycles = 0;
        for (int i = 0; i < nstim; i++) begin
            in_valid = 1'b1;
            in_x = stim[i];
            ok = 1'b0;
            g = 0;
            while (!ok && g < 50) begin
                @(negedge clk);
                ok = in_ready;
                @(posedge clk);
                #1;
                g++;
                cycles++;
            end
            if (ok) accepted++;
        end
        in_valid = 1'b0;
    endtask

    task automatic collect(input int n);
        int g = 0;
        while (rcv.size() < n && g < 200) begin
            @(posedge clk);
            #1;
            g++;
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [15:0] bp,
                             input logic [15:0] xoff, input logic [3:0] sh,
                             input logic ng, input logic zr,
                             input logic [15:0] bias);
        cfg_we = 1'b1;
        cfg_addr = a;
        cfg_bp = bp;
        cfg_xoff = xoff;
        cfg_shift = sh;
        cfg_neg = ng;
        cfg_zero = zr;
        cfg_bias = bias;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic do_commit(output logic busy_seen, output int wait_cyc);
        cfg_commit = 1'b1;
        @(posedge clk);
        #1;
        cfg_commit = 1'b0;
        @(negedge clk);
        busy_seen = cfg_busy;
        wait_cyc = 0;
        while (cfg_busy !== 1'b0 && wait_cyc < 50) begin
            @(negedge clk);
            wait_cyc++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        n_cmp++;
        if (out_y !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_out_y got %h want 0000", out_y);
        end
        n_cmp++;
        if (cfg_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_busy got %b want 0", cfg_busy);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_identity();
        logic l0, l1, l2;
        int   acc, cyc;
        in_valid = 1'b1;
        in_x = 16'h0108;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        l0 = out_valid;
        @(negedge clk);
        l1 = out_valid;
        @(negedge clk);
        l2 = out_valid;
        n_cmp++;
        if ({l0, l1, l2} !== 3'b001) begin
            n_bad++;
            $display("FAIL latency got %b%b%b want 001", l0, l1, l2);
        end
        n_cmp++;
        if (out_y !== 16'h0108) begin
            n_bad++;
            $display("FAIL latency_y got %h want 0108", out_y);
        end
        collect(1);
        rcv.delete();
        nstim = 3;
        stim[0] = 16'h0108; expv[0] = 16'h0108;
        stim[1] = 16'hFF80; expv[1] = 16'hFF80;
        stim[2] = 16'h7FFF; expv[2] = 16'h7FFF;
        push_all(acc, cyc);
        n_cmp++;
        if (acc != 3 || cyc != 3) begin
            n_bad++;
            $display("FAIL ident_rate got %0d in %0d cycles want 3 in 3", acc, cyc);
        end
        collect(3);
        n_cmp++;
        if (rcv.size() != 3) begin
            n_bad++;
            $display("FAIL ident_count got %0d want 3", rcv.size());
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (i >= rcv.size() || rcv[i] !== expv[i]) begin
                n_bad++;
                $display("FAIL ident_y[%0d] got %h want %h", i,
                         (i < rcv.size()) ? rcv[i] : 16'hxxxx, expv[i]);
            end
        end
        rcv.delete();
    endtask

    task automatic test_relu();
        logic bs;
        int   wc, acc, cyc;
        cfg_write(4'd0, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b1, 16'h0000);
        do_commit(bs, wc);
        n_cmp++;
        if (bs !== 1'b1) begin
            n_bad++;
            $display("FAIL relu_busy_set got %b want 1", bs);
        end
        n_cmp++;
        if (cfg_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL relu_busy_clear got %b want 0", cfg_busy);
        end
        nstim = 4;
        stim[0] = 16'hFE50; expv[0] = 16'h0000;
        stim[1] = 16'h0040; expv[1] = 16'h0040;
        stim[2] = 16'h7FFF; expv[2] = 16'h7FFF;
        stim[3] = 16'hFFFF; expv[3] = 16'h0000;
        push_all(acc, cyc);
        collect(4);
        n_cmp++;
        if (rcv.size() != 4) begin
            n_bad++;
            $display("FAIL relu_count got %0d want 4", rcv.size());
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (i >= rcv.size() || rcv[i] !== expv[i]) begin
                n_bad++;
                $display("FAIL relu_y[%0d] got %h want %h", i,
                         (i < rcv.size()) ? rcv[i] : 16'hxxxx, expv[i]);
            end
        end
        rcv.delete();
    endtask

    task automatic test_silu();
        logic bs;
        int   wc, acc, cyc;
        cfg_write(4'd0, 16'hFF80, 16'h0000, 4'd0, 1'b0, 1'b1, 16'h0000);
        cfg_write(4'd1, 16'h0108, 16'hFF80, 4'd1, 1'b0, 1'b0, 16'hFFC3);
        do_commit(bs, wc);
        nstim = 5;
        stim[0] = 16'h0000; expv[0] = 16'h0003;
        stim[1] = 16'h0100; expv[1] = 16'h0083;
        stim[2] = 16'hFF80; expv[2] = 16'hFFC3;
        stim[3] = 16'h0108; expv[3] = 16'h0108;
        stim[4] = 16'hFF7F; expv[4] = 16'h0000;
        push_all(acc, cyc);
        collect(5);
        n_cmp++;
        if (rcv.size() != 5) begin
            n_bad++;
            $display("FAIL silu_count got %0d want 5", rcv.size());
        end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (i >= rcv.size() || rcv[i] !== expv[i]) begin
                n_bad++;
                $display("FAIL silu_y[%0d] got %h want %h", i,
                         (i < rcv.size()) ? rcv[i] : 16'hxxxx, expv[i]);
            end
        end
        rcv.delete();
    endtask

    task automatic test_saturation();
        logic bs;
        int   wc, acc, cyc;
        cfg_write(4'd15, 16'h7FFF, 16'h8000, 4'd0, 1'b0, 1'b0, 16'h7000);
        do_commit(bs, wc);
        nstim = 2;
        stim[0] = 16'h7FFF; expv[0] = 16'h7FFF;
        stim[1] = 16'h7FFE; expv[1] = 16'h7FFE;
        push_all(acc, cyc);
        collect(2);
        n_cmp++;
        if (rcv.size() != 2) begin
            n_bad++;
            $display("FAIL satp_count got %0d want 2", rcv.size());
        end
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (i >= rcv.size() || rcv[i] !== expv[i]) begin
                n_bad++;
                $display("FAIL satp_y[%0d] got %h want %h", i,
                         (i < rcv.size()) ? rcv[i] : 16'hxxxx, expv[i]);
            end
        end
        rcv.delete();
        cfg_write(4'd15, 16'h7FFF, 16'h0000, 4'd0, 1'b1, 1'b0, 16'h8000);
        do_commit(bs, wc);
        nstim = 1;
        stim[0] = 16'h7FFF;
        push_all(acc, cyc);
        collect(1);
        n_cmp++;
        if (rcv.size() != 1 || rcv[0] !== 16'h8000) begin
            n_bad++;
            $display("FAIL satn_y got %h (n=%0d) want 8000", rcv[0], rcv.size());
        end
        rcv.delete();
    endtask

    task automatic test_backpressure();
        int          acc, cyc;
        logic [15:0] y0;
        logic        v0;
        int          unstable;
        nstim = 8;
        for (int i = 0; i < 8; i++) begin
            stim[i] = 16'h0110 + 16'(i * 16);
            expv[i] = stim[i];
        end
        unstable = 0;
        fork
            push_all(acc, cyc);
            begin
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b0;
                @(negedge clk);
                y0 = out_y;
                v0 = out_valid;
                repeat (5) begin
                    @(negedge clk);
                    if (out_y !== y0 || out_valid !== v0) unstable++;
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        n_cmp++;
        if (v0 !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_valid_at_stall got %b want 1", v0);
        end
        n_cmp++;
        if (unstable != 0) begin
            n_bad++;
            $display("FAIL bp_stable got %0d changes want 0", unstable);
        end
        n_cmp++;
        if (acc != 8) begin
            n_bad++;
            $display("FAIL bp_accepted got %0d want 8", acc);
        end
        collect(8);
        n_cmp++;
        if (rcv.size() != 8) begin
            n_bad++;
            $display("FAIL bp_count got %0d want 8", rcv.size());
        end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (i >= rcv.size() || rcv[i] !== expv[i]) begin
                n_bad++;
                $display("FAIL bp_y[%0d] got %h want %h", i,
                         (i < rcv.size()) ? rcv[i] : 16'hxxxx, expv[i]);
            end
        end
        rcv.delete();
    endtask

    task automatic test_commit_inflight();
        int   acc, cyc, g, leak;
        logic b0, r0;
        cfg_write(4'd15, 16'h7FFF, 16'h0000, 4'd0, 1'b0, 1'b0, 16'h0000);
        nstim = 3;
        for (int i = 0; i < 3; i++) stim[i] = 16'h7FFF;
        push_all(acc, cyc);
        cfg_commit = 1'b1;
        @(posedge clk);
        #1;
        cfg_commit = 1'b0;
        @(negedge clk);
        b0 = cfg_busy;
        r0 = in_ready;
        n_cmp++;
        if (b0 !== 1'b1 || r0 !== 1'b0) begin
            n_bad++;
            $display("FAIL cmt_drain busy=%b ready=%b want 1 0", b0, r0);
        end
        g = 0;
        leak = 0;
        while (cfg_busy !== 1'b0 && g < 50) begin
            if (in_ready !== 1'b0) leak++;
            @(negedge clk);
            g++;
        end
        n_cmp++;
        if (cfg_busy !== 1'b0 || leak != 0) begin
            n_bad++;
            $display("FAIL cmt_swap busy=%b ready_leaks=%0d want 0 0", cfg_busy, leak);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL cmt_ready_back got %b want 1", in_ready);
        end
        @(posedge clk);
        #1;
        collect(3);
        n_cmp++;
        if (rcv.size() != 3) begin
            n_bad++;
            $display("FAIL cmt_count got %0d want 3", rcv.size());
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (i >= rcv.size() || rcv[i] !== 16'h8000) begin
                n_bad++;
                $display("FAIL cmt_old_y[%0d] got %h want 8000", i,
                         (i < rcv.size()) ? rcv[i] : 16'hxxxx);
            end
        end
        rcv.delete();
        nstim = 1;
        stim[0] = 16'h7FFF;
        push_all(acc, cyc);
        collect(1);
        n_cmp++;
        if (rcv.size() != 1 || rcv[0] !== 16'h7FFF) begin
            n_bad++;
            $display("FAIL cmt_new_y got %h (n=%0d) want 7FFF", rcv[0], rcv.size());
        end
        rcv.delete();
    endtask

    task automatic test_reset_mid();
        int   acc, cyc;
        logic vb, va;
        logic [15:0] ya;
        nstim = 6;
        for (int i = 0; i < 6; i++) stim[i] = 16'h0200 + 16'(i);
        fork
            push_all(acc, cyc);
            begin
                repeat (3) @(posedge clk);
                #2;
                vb = out_valid;
                rst_n = 1'b0;
                #1;
                va = out_valid;
                ya = out_y;
                repeat (4) @(posedge clk);
                #2;
                rst_n = 1'b1;
            end
        join
        n_cmp++;
        if (vb !== 1'b1) begin
            n_bad++;
            $display("FAIL rstm_pre_valid got %b want 1", vb);
        end
        n_cmp++;
        if (va !== 1'b0 || ya !== 16'h0000) begin
            n_bad++;
            $display("FAIL rstm_flush valid=%b y=%h want 0 0000", va, ya);
        end
        @(posedge clk);
        #1;
        rcv.delete();
        nstim = 2;
        stim[0] = 16'hFE50; expv[0] = 16'hFE50;
        stim[1] = 16'hFF7F; expv[1] = 16'hFF7F;
        push_all(acc, cyc);
        collect(2);
        n_cmp++;
        if (rcv.size() != 2) begin
            n_bad++;
            $display("FAIL rstm_count got %0d want 2", rcv.size());
        end
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (i >= rcv.size() || rcv[i] !== expv[i]) begin
                n_bad++;
                $display("FAIL rstm_ident_y[%0d] got %h want %h", i,
                         (i < rcv.size()) ? rcv[i] : 16'hxxxx, expv[i]);
            end
        end
        rcv.delete();
    endtask

    initial begin
        test_reset();
        test_identity();
        test_relu();
        test_silu();
        test_saturation();
        test_backpressure();
        test_commit_inflight();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
